// File: rtl/fmeter_ctrl.sv
// Sequencer for a reciprocal frequency meter: clears the meter, opens a gate of
// selectable length, waits for the synchronized gate to close and latches the counts.
module fmeter_ctrl #(
    parameter int unsigned GATE0 = 1000,
    parameter int unsigned GATE1 = 10000,
    parameter int unsigned GATE2 = 100000,
    parameter int unsigned GATE3 = 1000000,
    parameter int unsigned TMO   = 2000000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        stop,
    input  logic        cont,
    input  logic [1:0]  gate_sel,
    output logic        m_clr,
    output logic        m_ss,
    input  logic        m_sta,
    input  logic        m_ovx,
    input  logic        m_ovs,
    input  logic [19:0] m_cntx,
    input  logic [19:0] m_cnts,
    output logic        busy,
    output logic        done,
    output logic [19:0] res_cntx,
    output logic [19:0] res_cnts,
    output logic        ovf,
    output logic        nosig
);

    localparam int unsigned CW = 20;
    localparam int unsigned TW = 21;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ARM   = 3'd2,
        S_GATE  = 3'd3,
        S_DRAIN = 3'd4,
        S_LATCH = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      gsel_q, gsel_d;
    logic [CW-1:0]   gcnt_q, gcnt_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            seen_q, seen_d;

    logic            m_clr_q, m_clr_d;
    logic            m_ss_q, m_ss_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   res_cntx_q, res_cntx_d;
    logic [CW-1:0]   res_cnts_q, res_cnts_d;
    logic            ovf_q, ovf_d;
    logic            nosig_q, nosig_d;

    logic            drain_ok, drain_nosig, drain_tmo;

    function automatic logic [CW-1:0] gate_len(input logic [1:0] sel);
        case (sel)
            2'd0:    gate_len = CW'(GATE0);
            2'd1:    gate_len = CW'(GATE1);
            2'd2:    gate_len = CW'(GATE2);
            default: gate_len = CW'(GATE3);
        endcase
    endfunction

    // Drain exit reasons: gate closed normally, never opened, or stuck open.
    assign drain_ok    = !m_sta && seen_q;
    assign drain_nosig = !m_sta && !seen_q && (tmo_q >= TW'(2));
    assign drain_tmo   = m_sta && (tmo_q >= TW'(TMO));

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            gsel_q     <= 2'd0;
            gcnt_q     <= '0;
            tmo_q      <= '0;
            seen_q     <= 1'b0;
            m_clr_q    <= 1'b0;
            m_ss_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_cntx_q <= '0;
            res_cnts_q <= '0;
            ovf_q      <= 1'b0;
            nosig_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gsel_q     <= gsel_d;
            gcnt_q     <= gcnt_d;
            tmo_q      <= tmo_d;
            seen_q     <= seen_d;
            m_clr_q    <= m_clr_d;
            m_ss_q     <= m_ss_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            res_cntx_q <= res_cntx_d;
            res_cnts_q <= res_cnts_d;
            ovf_q      <= ovf_d;
            nosig_q    <= nosig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gsel_d  = gsel_q;
        gcnt_d  = gcnt_q;
        tmo_d   = tmo_q;
        seen_d  = seen_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_CLEAR;
                    gsel_d  = gate_sel;
                end
            end
            S_CLEAR: begin
                state_d = S_ARM;
                seen_d  = 1'b0;
            end
            S_ARM: begin
                state_d = S_GATE;
                gcnt_d  = gate_len(gsel_q);
                tmo_d   = '0;
            end
            S_GATE: begin
                if (m_sta) begin
                    seen_d = 1'b1;
                end
                gcnt_d = gcnt_q - CW'(1);
                if (gcnt_q <= CW'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                tmo_d = tmo_q + TW'(1);
                if (drain_ok || drain_nosig || drain_tmo) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                state_d = (cont && !stop) ? S_CLEAR : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins everywhere except LATCH, which always finishes its result.
        if (stop && state_q != S_LATCH) begin
            state_d = S_IDLE;
        end
    end

    // Outputs are decoded from the next state so the registers line up with the state.
    always_comb begin
        m_clr_d    = (state_d == S_CLEAR);
        m_ss_d     = (state_d == S_GATE);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_LATCH);
        res_cntx_d = res_cntx_q;
        res_cnts_d = res_cnts_q;
        ovf_d      = ovf_q;
        nosig_d    = nosig_q;
        if (state_d == S_LATCH) begin
            res_cntx_d = m_cntx;
            res_cnts_d = m_cnts;
            ovf_d      = m_ovx | m_ovs;
            nosig_d    = !drain_ok;
        end
    end

    assign m_clr    = m_clr_q;
    assign m_ss     = m_ss_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign res_cntx = res_cntx_q;
    assign res_cnts = res_cnts_q;
    assign ovf      = ovf_q;
    assign nosig    = nosig_q;

endmodule
